// File: rtl/pc_stos_fetch.sv
// Program counter with a return-address stack for CALL/RET and interrupt entry.
// Emits the program-memory address plus the stack status flags the decoder tests.
module pc_stos_fetch #(
  parameter int PC_WIDTH = 8,
  parameter int STOS_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VEC = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic ID_rst,
  input  logic skok_ID,
  input  logic [PC_WIDTH-1:0] adres_skok_ID,
  input  logic skok_pc_ID,
  input  logic ID_push_pc,
  input  logic ID_pop_pc,
  input  logic jest_przerwanie,
  output logic [PC_WIDTH-1:0] pc,
  output logic stos_pc_empty,
  output logic stos_pc_full,
  output logic [$clog2(STOS_DEPTH+1)-1:0] stos_pc_count,
  output logic stos_pc_error
);

  localparam int CW = $clog2(STOS_DEPTH+1);
  localparam int IW = $clog2(STOS_DEPTH);

  localparam logic [2:0] OP_RST  = 3'd0;
  localparam logic [2:0] OP_ILL  = 3'd1;
  localparam logic [2:0] OP_RET  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_JMP  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;

  logic [PC_WIDTH-1:0] stos [STOS_DEPTH];
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ret;
  logic [PC_WIDTH-1:0] top;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [2:0] op;

  assign pc_inc = pc + 1'b1;
  // Interrupt entry saves the preempted pc so that instruction re-executes.
  assign ret = jest_przerwanie ? pc : pc_inc;
  assign wr_idx = stos_pc_count[IW-1:0];
  assign rd_idx = wr_idx - 1'b1;
  assign top = stos[rd_idx];

  assign stos_pc_empty = (stos_pc_count == '0);
  assign stos_pc_full = (stos_pc_count == CW'(STOS_DEPTH));

  // Priority resolved here so the update below sees exactly one opcode.
  always_comb begin
    op = OP_INC;
    if (ID_rst)
      op = OP_RST;
    else if (ID_push_pc && ID_pop_pc)
      op = OP_ILL;
    else if (skok_ID && skok_pc_ID && ID_pop_pc)
      op = OP_RET;
    else if (skok_ID && ID_push_pc)
      op = OP_CALL;
    else if (skok_ID)
      op = OP_JMP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VEC;
      stos_pc_count <= '0;
      stos_pc_error <= 1'b0;
      for (int i = 0; i < STOS_DEPTH; i++)
        stos[i] <= '0;
    end else if (ce) begin
      unique case (op)
        OP_RST: begin
          pc <= RESET_VEC;
          stos_pc_count <= '0;
        end
        OP_ILL: begin
          pc <= pc_inc;
          stos_pc_error <= 1'b1;
        end
        OP_RET: begin
          if (stos_pc_empty) begin
            pc <= pc_inc;
            stos_pc_error <= 1'b1;
          end else begin
            pc <= top;
            stos_pc_count <= stos_pc_count - 1'b1;
          end
        end
        OP_CALL: begin
          pc <= adres_skok_ID;
          if (stos_pc_full) begin
            stos_pc_error <= 1'b1;
          end else begin
            stos[wr_idx] <= ret;
            stos_pc_count <= stos_pc_count + 1'b1;
          end
        end
        OP_JMP: pc <= adres_skok_ID;
        OP_INC: pc <= pc_inc;
        default: pc <= pc_inc;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_stos_fetch.sv
// Bench for pc_stos_fetch: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_pc_stos_fetch;

  localparam int D = 8;
  localparam logic [7:0] RV = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic ID_rst = 1'b0;
  logic skok_ID = 1'b0;
  logic [7:0] adres_skok_ID = 8'h00;
  logic skok_pc_ID = 1'b0;
  logic ID_push_pc = 1'b0;
  logic ID_pop_pc = 1'b0;
  logic jest_przerwanie = 1'b0;
  logic [7:0] pc;
  logic stos_pc_empty;
  logic stos_pc_full;
  logic [3:0] stos_pc_count;
  logic stos_pc_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mpc = RV;
  logic [7:0] stk[$];
  logic merr = 1'b0;
  bit wrapped = 1'b0;

  pc_stos_fetch #(.PC_WIDTH(8), .STOS_DEPTH(D), .RESET_VEC(RV)) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .ID_rst(ID_rst),
    .skok_ID(skok_ID),
    .adres_skok_ID(adres_skok_ID),
    .skok_pc_ID(skok_pc_ID),
    .ID_push_pc(ID_push_pc),
    .ID_pop_pc(ID_pop_pc),
    .jest_przerwanie(jest_przerwanie),
    .pc(pc),
    .stos_pc_empty(stos_pc_empty),
    .stos_pc_full(stos_pc_full),
    .stos_pc_count(stos_pc_count),
    .stos_pc_error(stos_pc_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, int'(pc), int'(mpc));
    chk({tag, ".count"}, int'(stos_pc_count), stk.size());
    chk({tag, ".empty"}, int'(stos_pc_empty), int'(stk.size() == 0));
    chk({tag, ".full"}, int'(stos_pc_full), int'(stk.size() == D));
    chk({tag, ".error"}, int'(stos_pc_error), int'(merr));
  endtask

  // Reference behaviour, written directly from the rule list.
  task automatic model;
    if (rst) begin
      mpc = RV;
      stk.delete();
      merr = 1'b0;
    end else if (ce) begin
      if (ID_rst) begin
        mpc = RV;
        stk.delete();
      end else if (ID_push_pc && ID_pop_pc) begin
        mpc = mpc + 8'd1;
        merr = 1'b1;
      end else if (skok_ID && skok_pc_ID && ID_pop_pc) begin
        if (stk.size() > 0) mpc = stk.pop_back();
        else begin
          mpc = mpc + 8'd1;
          merr = 1'b1;
        end
      end else if (skok_ID && ID_push_pc) begin
        if (stk.size() < D) stk.push_back(jest_przerwanie ? mpc : mpc + 8'd1);
        else merr = 1'b1;
        mpc = adres_skok_ID;
      end else if (skok_ID) begin
        mpc = adres_skok_ID;
      end else begin
        mpc = mpc + 8'd1;
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic c,
                      input logic ir, input logic sk, input logic skpc,
                      input logic pu, input logic po, input logic intr,
                      input logic [7:0] adr);
    rst = r; ce = c; ID_rst = ir; skok_ID = sk; skok_pc_ID = skpc;
    ID_push_pc = pu; ID_pop_pc = po; jest_przerwanie = intr;
    adres_skok_ID = adr;
    @(posedge clk);
    #1;
    model();
    check_all(tag);
  endtask

  task automatic inc(input string tag);
    step(tag, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_rst;
    step("reset", 1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic call(input string tag, input logic [7:0] adr);
    step(tag, 0, 1, 0, 1, 0, 1, 0, 0, adr);
  endtask

  task automatic retn(input string tag);
    step(tag, 0, 1, 0, 1, 1, 0, 1, 0, 8'h00);
  endtask

  initial begin
    logic [7:0] saved;
    do_rst();
    do_rst();
    chk("reset.pc_const", int'(pc), 0);

    for (int i = 0; i < 300; i++) begin
      inc("seq");
      if (pc == 8'h00 && i > 0) wrapped = 1'b1;
    end
    chk("seq.wrapped", int'(wrapped), 1);
    chk("seq.final_pc", int'(pc), 300 % 256);

    do_rst();
    for (int i = 0; i < 16; i++) inc("to10");
    chk("call.at", int'(pc), 'h10);
    call("call", 8'h40);
    chk("call.pc", int'(pc), 'h40);
    chk("call.cnt", int'(stos_pc_count), 1);
    retn("ret");
    chk("ret.pc", int'(pc), 'h11);
    chk("ret.cnt", int'(stos_pc_count), 0);

    step("jmp22", 0, 1, 0, 1, 0, 0, 0, 0, 8'h22);
    step("irq", 0, 1, 0, 1, 0, 1, 0, 1, 8'h08);
    chk("irq.pc", int'(pc), 'h08);
    inc("irq.body");
    retn("reti");
    chk("reti.pc", int'(pc), 'h22);

    for (int i = 0; i < D; i++) call("nest", 8'(8'h80 + i * 4));
    chk("ovf.full", int'(stos_pc_full), 1);
    saved = pc;
    call("ovf", 8'h06);
    chk("ovf.pc", int'(pc), 'h06);
    chk("ovf.cnt", int'(stos_pc_count), D);
    chk("ovf.err", int'(stos_pc_error), 1);
    chk("ovf.prev", int'(saved), 'h80 + (D - 1) * 4);
    for (int i = D - 1; i >= 0; i--) begin
      retn("lifo");
      chk("lifo.pc", int'(pc), i == 0 ? 'h23 : 'h80 + (i - 1) * 4 + 1);
    end

    do_rst();
    chk("clr.err", int'(stos_pc_error), 0);
    for (int i = 0; i < 3; i++) inc("pre_under");
    retn("under");
    chk("under.pc", int'(pc), 4);
    chk("under.err", int'(stos_pc_error), 1);
    step("idrst", 0, 1, 1, 0, 0, 0, 0, 0, 8'h00);
    chk("idrst.err_kept", int'(stos_pc_error), 1);

    do_rst();
    call("pp.pre", 8'h30);
    step("pushpop", 0, 1, 0, 1, 1, 1, 1, 0, 8'h55);
    chk("pushpop.pc", int'(pc), 'h31);
    chk("pushpop.cnt", int'(stos_pc_count), 1);
    chk("pushpop.err", int'(stos_pc_error), 1);
    step("nojmp_push", 0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    step("nojmp_pop", 0, 1, 0, 0, 1, 0, 1, 0, 8'h00);
    do_rst();

    call("hold.pre", 8'h50);
    call("hold.pre", 8'h60);
    for (int i = 0; i < 5; i++)
      step("hold", 0, 0, 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    chk("hold.pc", int'(pc), 'h60);
    call("idrst.pre", 8'h70);
    chk("idrst.cnt3", int'(stos_pc_count), 3);
    step("idrst3", 0, 1, 1, 1, 0, 1, 0, 0, 8'h11);
    chk("idrst3.pc", int'(pc), 0);
    chk("idrst3.cnt", int'(stos_pc_count), 0);

    call("rstpush.pre", 8'h44);
    step("rstpush", 1, 1, 0, 1, 0, 1, 0, 0, 8'h99);
    chk("rstpush.cnt", int'(stos_pc_count), 0);

    for (int i = 0; i < 500; i++) begin
      logic r, sk, pu, po, skpc;
      r = ($urandom_range(0, 63) == 0);
      sk = ($urandom_range(0, 2) != 0);
      pu = ($urandom_range(0, 2) == 0);
      po = ($urandom_range(0, 2) == 0);
      skpc = po ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      step("rand", r, ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 40) == 0), sk, skpc, pu, po,
           1'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
